button_position_ctrl: RTL and testbench

Downstream consumer of the two-button debouncer: takes its debounced right/left level signals on the `new_clk` domain and converts them into single-step move events with hold-to-repeat. It maintains a saturating position register for the display/game logic. Both-buttons-pressed is treated as a lockout with no motion.

---
 rtl/button_position_ctrl.sv | 159 +++++++++++++++
 tb/tb_button_position_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_position_ctrl.sv
// Converts debounced right/left button levels into saturating position steps
// with hold-to-repeat. Pressing both buttons locks out motion until both are
// released. All state is clocked on new_clk with an asynchronous active-low reset.
//
// The buttons are level inputs with no handshake. A step happens on the edge
// that samples a new press, or on a repeat edge. The matching step pulse is
// high for the following cycle. state_o shows the FSM state for debug.
module button_position_ctrl #(
  parameter int POS_WIDTH    = 4,
  parameter int POS_MAX      = 15,
  parameter int POS_INIT     = 0,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic                 new_clk,
  input  logic                 rst_n,
  input  logic                 signal_1,
  input  logic                 signal_2,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_right,
  output logic                 step_left,
  output logic                 at_min,
  output logic                 at_max,
  output logic                 locked,
  output logic [1:0]           state_o
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0]        DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0]        RATE_LOAD  = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0]        RCNT_ONE   = CW'(1);
  localparam logic [POS_WIDTH-1:0] POS_MAX_V  = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] POS_INIT_V = POS_WIDTH'(POS_INIT);
  localparam logic [POS_WIDTH-1:0] POS_ONE    = POS_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_R = 2'd1,
    HOLD_L = 2'd2,
    BOTH   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          rcnt_q, rcnt_d;
  logic                   prev_1_q, prev_2_q;
  logic [POS_WIDTH-1:0]   pos_q, pos_d;
  logic                   step_r_q, step_r_d;
  logic                   step_l_q, step_l_d;
  logic                   locked_q, locked_d;

  logic rise_1, rise_2;
  logic req_r, req_l;

  // A press is a high input whose previous sample was low.
  assign rise_1 = signal_1 & ~prev_1_q;
  assign rise_2 = signal_2 & ~prev_2_q;

  // Next-state, repeat timing and saturating position update.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    req_r   = 1'b0;
    req_l   = 1'b0;
    case (state_q)
      IDLE: begin
        if (signal_1 && signal_2) begin
          state_d = BOTH;
        end else if (rise_1) begin
          state_d = HOLD_R;
          req_r   = 1'b1;
          rcnt_d  = DELAY_LOAD;
        end else if (rise_2) begin
          state_d = HOLD_L;
          req_l   = 1'b1;
          rcnt_d  = DELAY_LOAD;
        end
      end
      HOLD_R: begin
        // Release wins over a repeat that would fire on the same edge.
        if (!signal_1) begin
          state_d = IDLE;
        end else if (signal_2) begin
          state_d = BOTH;
        end else if (rcnt_q == '0) begin
          req_r  = 1'b1;
          rcnt_d = RATE_LOAD;
        end else begin
          rcnt_d = rcnt_q - RCNT_ONE;
        end
      end
      HOLD_L: begin
        if (!signal_2) begin
          state_d = IDLE;
        end else if (signal_1) begin
          state_d = BOTH;
        end else if (rcnt_q == '0) begin
          req_l  = 1'b1;
          rcnt_d = RATE_LOAD;
        end else begin
          rcnt_d = rcnt_q - RCNT_ONE;
        end
      end
      BOTH: begin
        // Only a full release leaves lockout.
        if (!signal_1 && !signal_2) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A step at a limit is swallowed, but the FSM and counter still advance.
    step_r_d = req_r && (pos_q < POS_MAX_V);
    step_l_d = req_l && (pos_q != '0);
    pos_d    = pos_q;
    if (step_r_d) begin
      pos_d = pos_q + POS_ONE;
    end else if (step_l_d) begin
      pos_d = pos_q - POS_ONE;
    end
    locked_d = (state_d == BOTH);
  end

  // State, counter, input history and registered outputs.
  always_ff @(posedge new_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      prev_1_q <= 1'b0;
      prev_2_q <= 1'b0;
      pos_q    <= POS_INIT_V;
      step_r_q <= 1'b0;
      step_l_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      prev_1_q <= signal_1;
      prev_2_q <= signal_2;
      pos_q    <= pos_d;
      step_r_q <= step_r_d;
      step_l_q <= step_l_d;
      locked_q <= locked_d;
    end
  end

  assign position   = pos_q;
  assign step_right = step_r_q;
  assign step_left  = step_l_q;
  assign at_min     = (pos_q == '0);
  assign at_max     = (pos_q == POS_MAX_V);
  assign locked     = locked_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_button_position_ctrl.sv
// Directed bench for button_position_ctrl with POS_INIT=7 and the default
// repeat timing (first repeat 8 cycles after the press, then every 4 cycles).
module tb_button_position_ctrl;

  logic       new_clk;
  logic       rst_n;
  logic       signal_1;
  logic       signal_2;
  logic [3:0] position;
  logic       step_right;
  logic       step_left;
  logic       at_min;
  logic       at_max;
  logic       locked;
  logic [1:0] state_o;

  int errors;
  int checks;

  button_position_ctrl #(
    .POS_WIDTH   (4),
    .POS_MAX     (15),
    .POS_INIT    (7),
    .REPEAT_DELAY(8),
    .REPEAT_RATE (4)
  ) dut (
    .new_clk   (new_clk),
    .rst_n     (rst_n),
    .signal_1  (signal_1),
    .signal_2  (signal_2),
    .position  (position),
    .step_right(step_right),
    .step_left (step_left),
    .at_min    (at_min),
    .at_max    (at_max),
    .locked    (locked),
    .state_o   (state_o)
  );

  // Clock and watchdog.
  initial begin
    new_clk = 1'b0;
    forever #5 new_clk = ~new_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Move to 1 time unit after the next rising edge. Drive and sample happen there.
  task automatic tick();
    @(posedge new_clk);
    #1;
  endtask

  task automatic press_once(input bit right);
    if (right) signal_1 = 1'b1; else signal_2 = 1'b1;
    tick();
    signal_1 = 1'b0;
    signal_2 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; signal_1 = 1'b0; signal_2 = 1'b0;
    tick(); tick();
    checks++; if (position !== 4'd7) begin errors++; $display("FAIL reset_pos: got %0d exp 7", position); end
    checks++; if ({step_right, step_left} !== 2'b00) begin errors++; $display("FAIL reset_steps: got %b exp 00", {step_right, step_left}); end
    checks++; if ({at_min, at_max, locked} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {at_min, at_max, locked}); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_o); end
    rst_n = 1'b1;
    tick();
    checks++; if (position !== 4'd7) begin errors++; $display("FAIL post_reset_pos: got %0d exp 7", position); end
  endtask

  task automatic test_single_press();
    int pulses;
    signal_1 = 1'b1;
    tick();
    checks++; if (position !== 4'd8) begin errors++; $display("FAIL single_pos: got %0d exp 8", position); end
    checks++; if ({step_right, step_left} !== 2'b10) begin errors++; $display("FAIL single_pulse: got %b exp 10", {step_right, step_left}); end
    signal_1 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (step_right || step_left) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL single_extra_pulses: got %0d exp 0", pulses); end
    checks++; if (position !== 4'd8) begin errors++; $display("FAIL single_hold_pos: got %0d exp 8", position); end
    press_once(1'b0);
    checks++; if (position !== 4'd7) begin errors++; $display("FAIL single_left_back: got %0d exp 7", position); end
  endtask

  task automatic test_repeat_left();
    logic [19:0] mask;
    int          rpulses;
    mask = '0; rpulses = 0;
    signal_2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      mask[i] = step_left;
      if (step_right) rpulses++;
    end
    checks++; if (mask !== 20'h11101) begin errors++; $display("FAIL repeat_mask: got %h exp 11101", mask); end
    checks++; if (position !== 4'd3) begin errors++; $display("FAIL repeat_pos: got %0d exp 3", position); end
    checks++; if (rpulses !== 0) begin errors++; $display("FAIL repeat_wrong_dir: got %0d exp 0", rpulses); end
    // This edge is where the next repeat would fire; the release must win.
    signal_2 = 1'b0;
    tick();
    checks++; if ({step_left, position} !== {1'b0, 4'd3}) begin errors++; $display("FAIL release_priority: got %b/%0d exp 0/3", step_left, position); end
  endtask

  task automatic test_saturate_right();
    int pulses;
    for (int i = 0; i < 10; i++) press_once(1'b1);
    checks++; if (position !== 4'd13) begin errors++; $display("FAIL climb_pos: got %0d exp 13", position); end
    pulses = 0;
    signal_1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step_right) pulses++;
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL sat_pulses: got %0d exp 2", pulses); end
    checks++; if ({position, at_max, at_min} !== {4'd15, 1'b1, 1'b0}) begin errors++; $display("FAIL sat_state: got %0d/%b/%b exp 15/1/0", position, at_max, at_min); end
    signal_1 = 1'b0;
    tick();
    signal_2 = 1'b1;
    tick();
    checks++; if ({position, step_left} !== {4'd14, 1'b1}) begin errors++; $display("FAIL sat_left: got %0d/%b exp 14/1", position, step_left); end
    signal_2 = 1'b0;
    tick();
    checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL sat_at_max_clear: got %b exp 0", at_max); end
  endtask

  task automatic test_lockout();
    int pulses;
    pulses = 0;
    signal_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (step_right || step_left) pulses++;
    end
    checks++; if ({pulses, position} !== {32'd1, 4'd15}) begin errors++; $display("FAIL lock_pre: got %0d/%0d exp 1/15", pulses, position); end
    signal_2 = 1'b1;
    tick();
    checks++; if ({locked, step_right, step_left} !== 3'b100) begin errors++; $display("FAIL lock_enter: got %b exp 100", {locked, step_right, step_left}); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (step_right || step_left) pulses++;
    end
    signal_2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (step_right || step_left) pulses++;
    end
    checks++; if ({locked, pulses, position} !== {1'b1, 32'd0, 4'd15}) begin errors++; $display("FAIL lock_hold: got %b/%0d/%0d exp 1/0/15", locked, pulses, position); end
    signal_1 = 1'b0;
    tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_exit: got %b exp 0", locked); end
    press_once(1'b0);
    checks++; if (position !== 4'd14) begin errors++; $display("FAIL lock_fresh_press: got %0d exp 14", position); end
  endtask

  task automatic test_simultaneous();
    signal_1 = 1'b1; signal_2 = 1'b1;
    tick();
    checks++; if ({locked, step_right, step_left, position} !== {3'b100, 4'd14}) begin errors++; $display("FAIL simul_lock: got %b/%0d exp 100/14", {locked, step_right, step_left}, position); end
    signal_1 = 1'b0; signal_2 = 1'b0;
    tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL simul_release: got %b exp 0", locked); end
  endtask

  task automatic test_floor();
    int pulses;
    pulses = 0;
    signal_2 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (step_left) pulses++;
    end
    checks++; if (pulses !== 14) begin errors++; $display("FAIL floor_pulses: got %0d exp 14", pulses); end
    checks++; if ({position, at_min} !== {4'd0, 1'b1}) begin errors++; $display("FAIL floor_state: got %0d/%b exp 0/1", position, at_min); end
    signal_2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_repeat();
    signal_1 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (position !== 4'd2) begin errors++; $display("FAIL mid_pre_pos: got %0d exp 2", position); end
    rst_n = 1'b0;
    #1;
    checks++; if ({position, step_right, step_left} !== {4'd7, 2'b00}) begin errors++; $display("FAIL mid_async_reset: got %0d/%b exp 7/00", position, {step_right, step_left}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({position, step_right} !== {4'd8, 1'b1}) begin errors++; $display("FAIL mid_first_edge: got %0d/%b exp 8/1", position, step_right); end
    signal_1 = 1'b0;
    tick();
    checks++; if ({position, step_right} !== {4'd8, 1'b0}) begin errors++; $display("FAIL mid_release: got %0d/%b exp 8/0", position, step_right); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_press();
    test_repeat_left();
    test_saturate_right();
    test_lockout();
    test_simultaneous();
    test_floor();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
